// File: rtl/fp_add_arbiter_if.sv
// Request/grant/result bundle for fp_add_arbiter.
// master: requester side (drives req/op). slave: arbiter side (drives gnt/done/res/busy).
interface fp_add_arbiter_if;
    logic        req0;
    logic        req1;
    logic [25:0] op0;
    logic [25:0] op1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        res_sign;
    logic [3:0]  res_exp;
    logic [7:0]  res_frac;
    logic        busy;

    modport master (
        output req0, req1, op0, op1,
        input  gnt0, gnt1, done0, done1, res_sign, res_exp, res_frac, busy
    );

    modport slave (
        input  req0, req1, op0, op1,
        output gnt0, gnt1, done0, done1, res_sign, res_exp, res_frac, busy
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Two-requester arbiter around a single shared combinational fp adder.
// Number format: {sign, exp[3:0], frac[7:0]}, frac normalized (MSB=1) or zero.
// Optional macro FP_ARB_ROUND_ROBIN_EN: round-robin tie breaking
// (default build: fixed priority, requester 0 wins ties).

// Combinational adder. Smaller operand is aligned by truncating right shift;
// carry-out renormalizes with exp+1 (saturates at exp=F, frac=FF);
// cancellation and exponent underflow both produce +0.
module enh_fp_adder (
    input  logic       sign_a,
    input  logic [3:0] exp_a,
    input  logic [7:0] frac_a,
    input  logic       sign_b,
    input  logic [3:0] exp_b,
    input  logic [7:0] frac_b,
    output logic       res_sign,
    output logic [3:0] res_exp,
    output logic [7:0] res_frac
);
    logic       a_big;
    logic       sign_big;
    logic [3:0] exp_big;
    logic [3:0] exp_small;
    logic [7:0] frac_big;
    logic [7:0] frac_small;
    logic [7:0] frac_shifted;
    logic [8:0] mag_sum;
    logic [7:0] mag_diff;
    logic [3:0] lz;

    // Align, add or subtract magnitudes, then renormalize.
    always_comb begin
        a_big        = {exp_a, frac_a} >= {exp_b, frac_b};
        sign_big     = a_big ? sign_a : sign_b;
        exp_big      = a_big ? exp_a  : exp_b;
        exp_small    = a_big ? exp_b  : exp_a;
        frac_big     = a_big ? frac_a : frac_b;
        frac_small   = a_big ? frac_b : frac_a;
        frac_shifted = frac_small >> (exp_big - exp_small);
        mag_sum      = {1'b0, frac_big} + {1'b0, frac_shifted};
        mag_diff     = frac_big - frac_shifted;

        lz = 4'd8;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mag_diff[i]) lz = 4'(7 - i);
        end

        res_sign = 1'b0;
        res_exp  = '0;
        res_frac = '0;
        if (frac_a == '0 && frac_b == '0) begin
            res_sign = 1'b0;
        end else if (frac_a == '0) begin
            res_sign = sign_b;
            res_exp  = exp_b;
            res_frac = frac_b;
        end else if (frac_b == '0) begin
            res_sign = sign_a;
            res_exp  = exp_a;
            res_frac = frac_a;
        end else if (sign_a == sign_b) begin
            res_sign = sign_big;
            if (mag_sum[8]) begin
                if (exp_big == 4'hF) begin
                    res_exp  = '1;
                    res_frac = '1;
                end else begin
                    res_exp  = exp_big + 4'd1;
                    res_frac = mag_sum[8:1];
                end
            end else begin
                res_exp  = exp_big;
                res_frac = mag_sum[7:0];
            end
        end else if (mag_diff != '0 && lz <= exp_big) begin
            res_sign = sign_big;
            res_exp  = exp_big - lz;
            res_frac = mag_diff << lz;
        end
    end
endmodule

module fp_add_arbiter #(
    parameter int unsigned ADD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    fp_add_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t      state;
    logic [25:0] op_q;
    logic        owner;
    logic [1:0]  cnt;
    logic        pick;
    logic        sum_sign;
    logic [3:0]  sum_exp;
    logic [7:0]  sum_frac;

`ifdef FP_ARB_ROUND_ROBIN_EN
    logic        last;

    // Tie goes to the requester not granted last; a lone request always wins.
    always_comb begin
        pick = bus.req1;
        if (bus.req0 && bus.req1) pick = ~last;
    end
`else
    // Fixed priority: requester 1 is chosen only when requester 0 is idle.
    always_comb begin
        pick = ~bus.req0;
    end
`endif

    enh_fp_adder u_adder (
        .sign_a   (op_q[25]),
        .exp_a    (op_q[24:21]),
        .frac_a   (op_q[20:13]),
        .sign_b   (op_q[12]),
        .exp_b    (op_q[11:8]),
        .frac_b   (op_q[7:0]),
        .res_sign (sum_sign),
        .res_exp  (sum_exp),
        .res_frac (sum_frac)
    );

    assign bus.busy = (state != IDLE);

    // Arbitration FSM: latch operands on grant, let the adder settle, publish result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            op_q         <= '0;
            owner        <= 1'b0;
            cnt          <= '0;
            bus.gnt0     <= 1'b0;
            bus.gnt1     <= 1'b0;
            bus.done0    <= 1'b0;
            bus.done1    <= 1'b0;
            bus.res_sign <= 1'b0;
            bus.res_exp  <= '0;
            bus.res_frac <= '0;
`ifdef FP_ARB_ROUND_ROBIN_EN
            last         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.done0 <= 1'b0;
                    bus.done1 <= 1'b0;
                    if (bus.req0 || bus.req1) begin
                        op_q     <= pick ? bus.op1 : bus.op0;
                        owner    <= pick;
                        bus.gnt0 <= ~pick;
                        bus.gnt1 <= pick;
                        cnt      <= '0;
`ifdef FP_ARB_ROUND_ROBIN_EN
                        last     <= pick;
`endif
                        state    <= ADD;
                    end
                end
                ADD: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'(ADD_LAT - 1)) begin
                        bus.res_sign <= sum_sign;
                        bus.res_exp  <= sum_exp;
                        bus.res_frac <= sum_frac;
                        bus.done0    <= ~owner;
                        bus.done1    <= owner;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    bus.gnt0  <= 1'b0;
                    bus.gnt1  <= 1'b0;
                    bus.done0 <= 1'b0;
                    bus.done1 <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: table of single operations on an
// ADD_LAT=1 instance, plus tie, late-operand-change and mid-op reset sequences
// (the latter two on an ADD_LAT=4 instance).
module tb_fp_add_arbiter;
    logic clk;
    logic reset_n;

    fp_add_arbiter_if a ();
    fp_add_arbiter_if b ();

    fp_add_arbiter #(.ADD_LAT(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(a));
    fp_add_arbiter #(.ADD_LAT(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        who;
        logic [25:0] op;
        logic [12:0] res;
    } vec_t;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One request on the ADD_LAT=1 instance, held until its done pulse.
    task automatic txn1(input int idx, input logic who, input logic [25:0] op, input logic [12:0] res);
        int n;
        @(negedge clk);
        if (who) begin a.op1 = op; a.req1 = 1'b1; end
        else     begin a.op0 = op; a.req0 = 1'b1; end
        n = 0;
        do begin @(negedge clk); n++; end while (!(who ? a.gnt1 : a.gnt0) && n < 10);
        chk($sformatf("v%0d gnt latency", idx), n, 1);
        chk($sformatf("v%0d other gnt", idx), who ? a.gnt0 : a.gnt1, 0);
        chk($sformatf("v%0d busy", idx), a.busy, 1);
        n = 0;
        while (!(who ? a.done1 : a.done0) && n < 10) begin @(negedge clk); n++; end
        chk($sformatf("v%0d done latency", idx), n, 1);
        chk($sformatf("v%0d result", idx), {a.res_sign, a.res_exp, a.res_frac}, res);
        a.req0 = 1'b0;
        a.req1 = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d idle after", idx), {a.gnt0, a.gnt1, a.done0, a.done1, a.busy}, 0);
        chk($sformatf("v%0d res held", idx), {a.res_sign, a.res_exp, a.res_frac}, res);
    endtask

    initial begin
        vec_t vecs[9];
        int   order[4];
        int   n, ndone, cyc, last_done, both_gnt, both_done;
        logic exp_who;

        vecs[0] = '{1'b0, {1'b0, 4'h2, 8'h80, 1'b0, 4'h2, 8'h80}, {1'b0, 4'h3, 8'h80}};
        vecs[1] = '{1'b1, {1'b0, 4'h5, 8'hC0, 1'b1, 4'h5, 8'hC0}, {1'b0, 4'h0, 8'h00}};
        vecs[2] = '{1'b0, {1'b0, 4'h4, 8'h80, 1'b0, 4'h3, 8'h80}, {1'b0, 4'h4, 8'hC0}};
        vecs[3] = '{1'b1, {1'b1, 4'h3, 8'hA0, 1'b0, 4'h3, 8'h80}, {1'b1, 4'h1, 8'h80}};
        vecs[4] = '{1'b0, {1'b0, 4'h2, 8'h80, 1'b1, 4'h5, 8'h90}, {1'b1, 4'h5, 8'h80}};
        vecs[5] = '{1'b1, {1'b0, 4'h0, 8'h00, 1'b1, 4'h6, 8'hB0}, {1'b1, 4'h6, 8'hB0}};
        vecs[6] = '{1'b0, {1'b0, 4'hF, 8'h80, 1'b0, 4'hF, 8'h80}, {1'b0, 4'hF, 8'hFF}};
        vecs[7] = '{1'b1, {1'b0, 4'h1, 8'h81, 1'b1, 4'h1, 8'h80}, {1'b0, 4'h0, 8'h00}};
        vecs[8] = '{1'b0, {1'b0, 4'h3, 8'hFF, 1'b0, 4'h0, 8'h80}, {1'b0, 4'h4, 8'h87}};

        reset_n = 1'b0;
        a.req0 = 1'b0; a.req1 = 1'b0; a.op0 = '0; a.op1 = '0;
        b.req0 = 1'b0; b.req1 = 1'b0; b.op0 = '0; b.op1 = '0;
        @(negedge clk);
        chk("reset grants", {a.gnt0, a.gnt1, a.done0, a.done1}, 0);
        chk("reset busy", a.busy, 0);
        chk("reset result", {a.res_sign, a.res_exp, a.res_frac}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) txn1(i, vecs[i].who, vecs[i].op, vecs[i].res);

        // Both requesters held continuously, starting from a fresh pointer.
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        a.op0 = vecs[0].op; a.op1 = vecs[1].op;
        a.req0 = 1'b1; a.req1 = 1'b1;
        for (int i = 0; i < 4; i++) order[i] = -1;
        ndone = 0; cyc = 0; last_done = 0; both_gnt = 0; both_done = 0;
        while (ndone < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (a.gnt0 && a.gnt1) both_gnt++;
            if (a.done0 && a.done1) both_done++;
            if (a.done0 || a.done1) begin
                order[ndone] = a.done1 ? 1 : 0;
                if (ndone > 0) chk($sformatf("tie interval %0d", ndone), cyc - last_done, 3);
                last_done = cyc;
                ndone++;
            end
        end
        a.req0 = 1'b0; a.req1 = 1'b0;
        chk("tie done count", ndone, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef FP_ARB_ROUND_ROBIN_EN
            exp_who = (i % 2 == 0);
`else
            exp_who = 1'b0;
`endif
            chk($sformatf("tie order %0d", i), order[i], {31'd0, exp_who});
        end
        chk("tie both gnt", both_gnt, 0);
        chk("tie both done", both_done, 0);
        @(negedge clk); @(negedge clk);

        // ADD_LAT=4: operand change during ADD must not leak into the result.
        b.op0 = vecs[0].op; b.req0 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!b.gnt0 && n < 10);
        chk("lat4 gnt latency", n, 1);
        b.op0 = vecs[2].op;
        n = 0;
        while (!b.done0 && n < 20) begin @(negedge clk); n++; end
        chk("lat4 done latency", n, 4);
        chk("lat4 result", {b.res_sign, b.res_exp, b.res_frac}, {1'b0, 4'h3, 8'h80});
        chk("lat4 gnt held", b.gnt0, 1);
        b.req0 = 1'b0;
        @(negedge clk); @(negedge clk);

        // Reset in the middle of an ADD_LAT=4 operation.
        b.op1 = vecs[2].op; b.req1 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!b.gnt1 && n < 10);
        chk("rst gnt latency", n, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst outputs", {b.gnt0, b.gnt1, b.done0, b.done1, b.busy}, 0);
        chk("rst result", {b.res_sign, b.res_exp, b.res_frac}, 0);
        @(negedge clk);
        chk("rst no done", {b.done0, b.done1}, 0);
        reset_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!b.gnt1 && n < 10);
        chk("rst regrant latency", n, 1);
        n = 0;
        while (!b.done1 && n < 20) begin @(negedge clk); n++; end
        chk("rst done latency", n, 4);
        chk("rst new result", {b.res_sign, b.res_exp, b.res_frac}, {1'b0, 4'h4, 8'hC0});
        b.req1 = 1'b0;
        @(negedge clk); @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 The block SHALL have parameter ADD_LAT, default 1, giving the number of cycles (legal 1..4) the shared combinational fp adder is allowed to settle.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 req0, req1  input  1 each  operation request from requester 0/1; held high with operands stable until that requester's done pulse.
REQ-006 op0, op1  input  26 each  packed operands {sign_a, exp_a[3:0], frac_a[7:0], sign_b, exp_b[3:0], frac_b[7:0]}; frac normalized (MSB=1) or all-zero.
REQ-007 gnt0, gnt1  output  1 each  registered; high while that requester's operation is in flight.
REQ-008 done0, done1  output  1 each  registered one-cycle pulse; the result for that requester is valid this cycle.
REQ-009 res_sign / res_exp / res_frac  output  1 / 4 / 8  registered shared result bus, same format as the operands.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 The block SHALL contain one internal enh_fp_adder instance, fed only from internal operand registers.
REQ-012 FSM states SHALL be IDLE, ADD, DONE.
REQ-013 IDLE: no request -> stay; any request -> select per REQ-017, load operand registers from the selected opN, set gntN, clear the settle counter, go to ADD.
REQ-014 ADD: increment the settle counter each cycle; in the cycle where the counter equals ADD_LAT-1, load res_* from the adder outputs, pulse doneN, go to DONE.
REQ-015 DONE: clear gntN, ignore requests, go to IDLE; done pulse width is exactly one cycle.
REQ-016 Latency: the done pulse SHALL occur ADD_LAT cycles after the first gnt cycle. Back-to-back throughput SHALL be one operation per ADD_LAT+2 cycles.
REQ-017 Selection SHALL follow the policy fixed by the configuration macro (REQ-024/025); with a single request active, that requester SHALL always win.
REQ-018 At most one of gnt0/gnt1 SHALL be high, and at most one of done0/done1 SHALL be high, in any cycle.
REQ-019 Changes on opN or reqN while in ADD or DONE SHALL NOT affect the in-flight result.
REQ-020 res_* SHALL hold the last result until the next done pulse.
REQ-021 A requester still asserting req in the IDLE cycle after its DONE SHALL be treated as a new request.

Reset
REQ-022 While reset_n is low: state=IDLE; gnt0, gnt1, done0, done1, busy=0; res_sign=0, res_exp=4'h0, res_frac=8'h00; operand registers, settle counter and last-grant pointer=0. This takes effect immediately, without waiting for clk.
REQ-023 If reset is asserted mid-operation, the operation SHALL be discarded with no done pulse. The first request after reset release SHALL be sampled on the first rising edge with reset_n high.

Configuration
REQ-024 With FP_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the requester not granted last SHALL win. The last-grant pointer SHALL update on each grant and reset to 0, so requester 1 wins the first tie.
REQ-025 Without FP_ARB_ROUND_ROBIN_EN: fixed priority, requester 0 always wins ties; the pointer logic SHALL be compiled out.

Verification
REQ-026 ADD_LAT=1, req0 with op0={0,4'h2,8'h80,0,4'h2,8'h80} -> gnt0 next cycle, then done0 one cycle later with res={0,4'h3,8'h80}, busy high for 2 cycles.
REQ-027 req1 with op1={0,4'h5,8'hC0,1,4'h5,8'hC0} -> done1 with res={0,4'h0,8'h00} (exact cancellation).
REQ-028 req0 and req1 both held continuously, round robin enabled -> grant order 1,0,1,0; done pulses every ADD_LAT+2 cycles; never both gnt high. Same stimulus without the macro -> grant order 0,0,0.
REQ-029 ADD_LAT=4, op0 changed during ADD -> result matches the operands latched at grant; done0 exactly 4 cycles after gnt0 rises.
REQ-030 reset_n pulsed low during ADD -> all outputs zero immediately, no done pulse. After release, req1 is granted on the first rising edge.
